tdm_demux: RTL and testbench

//   Receive end of the 4:1 channel multiplexer: takes one time-division-multiplexed

---
 rtl/tdm_demux.sv | 137 +++++++++++++
 tb/tb_tdm_demux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a time-division multiplexed link.
// Collects one word per valid beat into a shadow frame, aligned on frame_sync,
// and publishes each complete frame onto y in a single edge. Framing faults
// (sync arriving early, or missing where slot 0 is expected) pulse sync_err
// and never reach y.
module tdm_demux #(
  parameter  int WIDTH = 1,
  parameter  int NCH   = 4,
  localparam int SW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [NCH*WIDTH-1:0] y,
  output logic                 y_valid,
  output logic [SW-1:0]        slot,
  output logic                 locked,
  output logic                 sync_err
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [SW-1:0] SLOT_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NCH - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [SW-1:0]             r_slot;
  logic [SW-1:0]             w_slot_nxt;
  // Slots 0..NCH-2 only; the last word goes straight from din into y.
  logic [(NCH-1)*WIDTH-1:0]  r_shadow;
  logic [NCH*WIDTH-1:0]      r_y;
  logic                      r_y_valid;
  logic                      r_sync_err;
  logic                      w_wr_en;
  logic [SW-1:0]             w_wr_idx;
  logic                      w_complete;
  logic                      w_err;
  logic [NCH*WIDTH-1:0]      w_frame;

  // Alignment state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, slot advance, shadow write select and error/complete decode.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_slot;
    w_complete  = 1'b0;
    w_err       = 1'b0;
    if (din_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (frame_sync) begin
            w_wr_en     = 1'b1;
            w_wr_idx    = SLOT_ZERO;
            w_slot_nxt  = SLOT_ONE;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (frame_sync) begin
            // Early sync restarts the frame on this beat; partial data is abandoned.
            w_err      = (r_slot != SLOT_ZERO);
            w_wr_en    = 1'b1;
            w_wr_idx   = SLOT_ZERO;
            w_slot_nxt = SLOT_ONE;
          end else if (r_slot == SLOT_ZERO) begin
            w_err       = 1'b1;
            w_slot_nxt  = SLOT_ZERO;
            w_state_nxt = ST_HUNT;
          end else begin
            w_wr_en    = 1'b1;
            w_slot_nxt = r_slot + SLOT_ONE;
            w_complete = (r_slot == SLOT_LAST);
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_slot_nxt  = SLOT_ZERO;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Assemble the outgoing frame: stored slots plus the completing beat on top.
  always_comb begin
    w_frame = {din, r_shadow};
  end

  // Slot counter, shadow storage and registered frame/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot     <= SLOT_ZERO;
      r_shadow   <= {((NCH-1)*WIDTH){1'b0}};
      r_y        <= {(NCH*WIDTH){1'b0}};
      r_y_valid  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_slot     <= w_slot_nxt;
      r_y_valid  <= w_complete;
      r_sync_err <= w_err;
      if (w_complete) begin
        r_y <= w_frame;
      end
      for (int k = 0; k < NCH - 1; k++) begin
        if (w_wr_en && (w_wr_idx == SW'(k))) begin
          r_shadow[k*WIDTH +: WIDTH] <= din;
        end
      end
    end
  end

  assign y        = r_y;
  assign y_valid  = r_y_valid;
  assign slot     = r_slot;
  assign locked   = (r_state == ST_LOCKED);
  assign sync_err = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed framing scenarios followed by randomized traffic,
// checked every cycle against a queue-based frame model.
module tb_tdm_demux;

  localparam int WIDTH = 1;
  localparam int NCH   = 4;
  localparam int SW    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [WIDTH-1:0]     din = '0;
  logic                 din_valid = 1'b0;
  logic                 frame_sync = 1'b0;
  logic [NCH*WIDTH-1:0] y;
  logic                 y_valid;
  logic [SW-1:0]        slot;
  logic                 locked;
  logic                 sync_err;

  int checks = 0;
  int errors = 0;

  tdm_demux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .y(y), .y_valid(y_valid), .slot(slot),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Reference model: words collected so far in the current frame, lock flag,
  // and the outputs that must be visible after the latest edge.
  logic [WIDTH-1:0]     m_q[$];
  bit                   m_locked = 1'b0;
  logic [NCH*WIDTH-1:0] m_y = '0;
  bit                   m_yv = 1'b0;
  bit                   m_err = 1'b0;

  function automatic int exp_slot();
    return m_locked ? m_q.size() : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_locked = 1'b0;
      m_y = '0;
      m_yv = 1'b0;
      m_err = 1'b0;
    end else begin
      m_yv = 1'b0;
      m_err = 1'b0;
      if (din_valid) begin
        if (frame_sync) begin
          if (m_locked && m_q.size() != 0) m_err = 1'b1;
          m_q.delete();
          m_q.push_back(din);
          m_locked = 1'b1;
        end else if (m_locked) begin
          if (m_q.size() == 0) begin
            m_err = 1'b1;
            m_locked = 1'b0;
          end else begin
            m_q.push_back(din);
            if (m_q.size() == NCH) begin
              for (int k = 0; k < NCH; k++) m_y[k*WIDTH +: WIDTH] = m_q[k];
              m_yv = 1'b1;
              m_q.delete();
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("y", 32'(y), 32'(m_y));
    chk("y_valid", 32'(y_valid), 32'(m_yv));
    chk("slot", 32'(slot), 32'(exp_slot()));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("sync_err", 32'(sync_err), 32'(m_err));
  end

  task automatic beat(input logic d, input logic fs);
    @(negedge clk);
    din = d;
    frame_sync = fs;
    din_valid = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    din_valid = 1'b0;
    frame_sync = 1'b0;
    din = 1'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single frame 1,0,1,1.
    beat(1'b1, 1'b1);
    gap();
    chk("t2_locked", 32'(locked), 32'd1);
    chk("t2_slot1", 32'(slot), 32'd1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    gap();
    chk("t2_y", 32'(y), 32'hD);
    chk("t2_model_y", 32'(m_y), 32'hD);
    chk("t2_yv", 32'(y_valid), 32'd1);
    chk("t2_slot0", 32'(slot), 32'd0);
    gap();
    chk("t2_yv_pulse", 32'(y_valid), 32'd0);
    chk("t2_y_hold", 32'(y), 32'hD);

    // Frame 0,1,1,0 with gaps between beats.
    beat(1'b0, 1'b1); gap(); gap();
    beat(1'b1, 1'b0); gap();
    beat(1'b1, 1'b0); gap(); gap(); gap();
    chk("t3_no_early_yv", 32'(y_valid), 32'd0);
    beat(1'b0, 1'b0);
    gap();
    chk("t3_y", 32'(y), 32'h6);
    chk("t3_yv", 32'(y_valid), 32'd1);

    // Back-to-back frames 4'hA then 4'h5, channel 0 first.
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    chk("t4_yA", 32'(y), 32'hA);
    chk("t4_yvA", 32'(y_valid), 32'd1);
    beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    gap();
    chk("t4_y5", 32'(y), 32'h5);
    chk("t4_model_y5", 32'(m_y), 32'h5);
    chk("t4_yv5", 32'(y_valid), 32'd1);

    // Sync arriving at slot 2, then the restarted frame 1,1,1,0.
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b1);
    gap();
    chk("t5_err", 32'(sync_err), 32'd1);
    chk("t5_y_kept", 32'(y), 32'h5);
    chk("t5_yv", 32'(y_valid), 32'd0);
    chk("t5_slot", 32'(slot), 32'd1);
    beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    gap();
    chk("t5_y", 32'(y), 32'h7);
    chk("t5_yv_after", 32'(y_valid), 32'd1);

    // Missing sync where slot 0 is expected.
    beat(1'b1, 1'b0);
    gap();
    chk("t6_err", 32'(sync_err), 32'd1);
    chk("t6_unlocked", 32'(locked), 32'd0);
    beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    gap();
    chk("t6_hunt", 32'(locked), 32'd0);
    chk("t6_slot", 32'(slot), 32'd0);
    chk("t6_no_err", 32'(sync_err), 32'd0);
    beat(1'b0, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    gap();
    chk("t6_y", 32'(y), 32'hC);
    chk("t6_yv", 32'(y_valid), 32'd1);

    // Asynchronous reset in the middle of a frame.
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t1_y", 32'(y), 32'd0);
    chk("t1_yv", 32'(y_valid), 32'd0);
    chk("t1_slot", 32'(slot), 32'd0);
    chk("t1_locked", 32'(locked), 32'd0);
    chk("t1_err", 32'(sync_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic: mostly well-formed framing with occasional faults.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      din_valid  = ($urandom_range(0, 3) != 0);
      din        = 1'($urandom);
      frame_sync = (exp_slot() == 0);
      if ($urandom_range(0, 19) == 0) frame_sync = ~frame_sync;
    end
    gap();
    gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
